// File: rtl/misc_wb_pkg.sv
// Shared types for the misc-unit writeback queue: flags, FIFO entry and tag.
package misc_wb_pkg;

  localparam int unsigned DST_W  = 5;
  localparam int unsigned SZ_W   = 3;
  localparam int unsigned R_W    = 128;
  localparam int unsigned FLAG_W = 5;

  // Bit positions of each flag inside flags_t
  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_SIGN = 1;
  localparam int unsigned FLAG_OVR  = 2;
  localparam int unsigned FLAG_COUT = 3;
  localparam int unsigned FLAG_NAN  = 4;

  typedef struct packed {
    logic nan;
    logic cout;
    logic ovr;
    logic sign;
    logic zero;
  } flags_t;

  typedef struct packed {
    logic [DST_W-1:0] dst;
    logic [SZ_W-1:0]  sz;
    flags_t           flags;
    logic [R_W-1:0]   r;
  } entry_t;

  // One stage of the issue-to-result tag pipeline
  typedef struct packed {
    logic             valid;
    logic [DST_W-1:0] dst;
    logic [SZ_W-1:0]  sz;
  } tag_t;

  // Assemble the flag struct from the unit's individual flag wires
  function automatic flags_t pack_flags(input logic nan, input logic cout,
                                        input logic ovr, input logic sign,
                                        input logic zero);
    logic [FLAG_W-1:0] v;
    v            = '0;
    v[FLAG_ZERO] = zero;
    v[FLAG_SIGN] = sign;
    v[FLAG_OVR]  = ovr;
    v[FLAG_COUT] = cout;
    v[FLAG_NAN]  = nan;
    return flags_t'(v);
  endfunction

endpackage

// File: rtl/misc_result_queue_if.sv
// Issue, result and writeback signals between the misc unit, the queue and the arbiter.
interface misc_result_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  import misc_wb_pkg::*;

  logic                   ACT;
  logic [DST_W-1:0]       DSTi;
  logic [SZ_W-1:0]        SD;
  logic [R_W-1:0]         R;
  logic                   ZERO;
  logic                   SIGN;
  logic                   OVR;
  logic                   COUT;
  logic                   NaN;
  logic                   NEXT;
  logic                   WBV;
  logic                   WBACK;
  logic [DST_W-1:0]       WBDST;
  logic [SZ_W-1:0]        WBSZ;
  logic [R_W-1:0]         WBR;
  logic [FLAG_W-1:0]      WBFLAGS;
  logic [$clog2(DEPTH):0] COUNT;
  logic                   OVERRUN;

  // Issue/unit/arbiter side
  modport master (
    output ACT, DSTi, SD, R, ZERO, SIGN, OVR, COUT, NaN, WBACK,
    input  NEXT, WBV, WBDST, WBSZ, WBR, WBFLAGS, COUNT, OVERRUN
  );

  // Queue side
  modport slave (
    input  ACT, DSTi, SD, R, ZERO, SIGN, OVR, COUT, NaN, WBACK,
    output NEXT, WBV, WBDST, WBSZ, WBR, WBFLAGS, COUNT, OVERRUN
  );

endinterface

// File: rtl/misc_wb_fifo.sv
// Registered FIFO of writeback entries; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module misc_wb_fifo
  import misc_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  entry_t                 i_data,
  input  logic                   i_pop,
  output entry_t                 o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_wr;
  logic            w_rd;

  // Status and accepted push/pop strobes
  always_comb begin
    o_full  = (r_count == CW'(DEPTH));
    o_empty = (r_count == '0);
    w_rd    = i_pop & ~o_empty;
    w_wr    = i_push & (~o_full | w_rd);
    o_head  = r_mem[r_rptr];
    o_count = r_count;
  end

  // Storage; cleared on reset so the head reads zero when nothing was written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) r_mem[k] <= '0;
    end else if (w_wr) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers wrap naturally; occupancy separates full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/misc_result_queue.sv
// Writeback stage for the misc unit: tracks issued ops through the fixed
// result latency, captures results into a FIFO, and issues credits.
module misc_result_queue
  import misc_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  misc_result_queue_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + $clog2(LAT + 1) + 1;

  tag_t            r_tag [LAT];
  logic            r_next;
  logic            r_overrun;

  logic            w_push;
  logic            w_pop;
  logic            w_accept;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  entry_t          w_entry;
  entry_t          w_head;
  logic [SW-1:0]   w_inflight_next;
  logic [SW-1:0]   w_count_next;

  // Tag pipeline: stage 0 samples the issue every cycle, later stages shift
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < int'(LAT); k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= tag_t'{valid: bus.ACT, dst: bus.DSTi, sz: bus.SD};
      for (int k = 1; k < int'(LAT); k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Capture the unit output when the oldest tag is valid; pop on ack of a valid head
  always_comb begin
    w_push   = r_tag[LAT-1].valid;
    w_pop    = ~w_empty & bus.WBACK;
    w_accept = w_push & (~w_full | w_pop);
    w_entry  = entry_t'{
      dst:   r_tag[LAT-1].dst,
      sz:    r_tag[LAT-1].sz,
      flags: pack_flags(bus.NaN, bus.COUT, bus.OVR, bus.SIGN, bus.ZERO),
      r:     bus.R
    };
  end

  // Next-cycle occupancy and in-flight count, used to register the credit
  always_comb begin
    w_inflight_next = SW'(bus.ACT);
    for (int k = 0; k < int'(LAT) - 1; k++) begin
      w_inflight_next = w_inflight_next + SW'(r_tag[k].valid);
    end
    w_count_next = SW'(w_count) + SW'(w_accept) - SW'(w_pop);
  end

  // Credit and sticky protocol-error flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_next    <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      r_next    <= (w_count_next + w_inflight_next) < SW'(DEPTH);
      r_overrun <= r_overrun | (bus.ACT & ~r_next) | (w_push & ~w_accept);
    end
  end

  misc_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Drive the writeback side from the FIFO head
  always_comb begin
    bus.NEXT    = r_next;
    bus.OVERRUN = r_overrun;
    bus.WBV     = ~w_empty;
    bus.COUNT   = w_count;
    bus.WBDST   = w_head.dst;
    bus.WBSZ    = w_head.sz;
    bus.WBFLAGS = w_head.flags;
    bus.WBR     = w_head.r;
  end

endmodule

// File: tb/tb_misc_result_queue.sv
// Randomized bench for misc_result_queue against a queue-based reference model.
module tb_misc_result_queue;
  import misc_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  typedef struct {
    int         due;
    logic [4:0] dst;
    logic [2:0] sz;
  } pend_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   npop;
  bit   m_ovr;
  entry_t exp_q[$];
  pend_t  pend_q[$];

  misc_result_queue_if #(.DEPTH(DEPTH)) bus ();

  misc_result_queue #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_next();
    return (exp_q.size() + pend_q.size()) < DEPTH;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of stimulus and advance the model across the edge
  task automatic tick(input bit act, input logic [4:0] dst, input logic [2:0] sz,
                      input bit wback, input logic [127:0] r, input logic [4:0] fl);
    bit mn, pop, arrive;
    entry_t e;
    bus.ACT = act; bus.DSTi = dst; bus.SD = sz; bus.WBACK = wback; bus.R = r;
    {bus.NaN, bus.COUT, bus.OVR, bus.SIGN, bus.ZERO} = fl;
    mn     = m_next();
    pop    = wback && exp_q.size() > 0;
    arrive = pend_q.size() > 0 && pend_q[0].due == cyc;
    @(posedge clk);
    if (act && !mn) m_ovr = 1'b1;
    if (pop) begin void'(exp_q.pop_front()); npop++; end
    if (arrive) begin
      e.dst = pend_q[0].dst; e.sz = pend_q[0].sz; e.flags = flags_t'(fl); e.r = r;
      void'(pend_q.pop_front());
      if (exp_q.size() < DEPTH) exp_q.push_back(e);
      else m_ovr = 1'b1;
    end
    if (act) pend_q.push_back('{cyc + LAT, dst, sz});
    cyc++;
    @(negedge clk);
  endtask

  task automatic rtick(input bit act, input bit wback);
    tick(act, 5'($urandom), 3'($urandom), wback, rnd128(), 5'($urandom));
  endtask

  task automatic apply_reset();
    rst = 1'b1; bus.ACT = 1'b0; bus.WBACK = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); pend_q.delete(); m_ovr = 1'b0;
  endtask

  // Issue DEPTH ops with no acks and let them all land
  task automatic fill();
    for (int k = 0; k < DEPTH; k++) rtick(1'b1, 1'b0);
    for (int k = 0; k < LAT; k++) rtick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    checks++; if (bus.NEXT !== 1'b1) begin errors++; $display("FAIL rst_next: got %b exp 1", bus.NEXT); end
    checks++; if (bus.WBV !== 1'b0) begin errors++; $display("FAIL rst_wbv: got %b exp 0", bus.WBV); end
    checks++; if (bus.COUNT !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", bus.COUNT); end
    checks++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b exp 0", bus.OVERRUN); end
    checks++; if (bus.WBR !== 128'h0) begin errors++; $display("FAIL rst_wbr: got %h exp 0", bus.WBR); end
    checks++; if (bus.WBDST !== 5'h0) begin errors++; $display("FAIL rst_wbdst: got %h exp 0", bus.WBDST); end
    checks++; if (bus.WBSZ !== 3'h0) begin errors++; $display("FAIL rst_wbsz: got %h exp 0", bus.WBSZ); end
    checks++; if (bus.WBFLAGS !== 5'h0) begin errors++; $display("FAIL rst_wbflags: got %h exp 0", bus.WBFLAGS); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_op();
    tick(1'b1, 5'h0A, 3'b011, 1'b0, rnd128(), 5'($urandom));
    checks++; if (bus.WBV !== 1'b0) begin errors++; $display("FAIL single_wbv_t1: got %b exp 0", bus.WBV); end
    rtick(1'b0, 1'b0);
    checks++; if (bus.WBV !== 1'b0) begin errors++; $display("FAIL single_wbv_t2: got %b exp 0", bus.WBV); end
    tick(1'b0, 5'h1F, 3'b111, 1'b0, 128'h1234, 5'b00010);
    checks++; if (bus.WBV !== 1'b1) begin errors++; $display("FAIL single_wbv_t3: got %b exp 1", bus.WBV); end
    checks++; if (bus.WBDST !== 5'h0A) begin errors++; $display("FAIL single_dst: got %h exp 0a", bus.WBDST); end
    checks++; if (bus.WBSZ !== 3'd3) begin errors++; $display("FAIL single_sz: got %0d exp 3", bus.WBSZ); end
    checks++; if (bus.WBR !== 128'h1234) begin errors++; $display("FAIL single_r: got %h exp 1234", bus.WBR); end
    checks++; if (bus.WBFLAGS !== 5'b00010) begin errors++; $display("FAIL single_flags: got %b exp 00010", bus.WBFLAGS); end
    rtick(1'b0, 1'b0);
    checks++; if (bus.WBR !== 128'h1234) begin errors++; $display("FAIL single_hold: got %h exp 1234", bus.WBR); end
    rtick(1'b0, 1'b1);
    checks++; if (bus.WBV !== 1'b0) begin errors++; $display("FAIL single_popped: got %b exp 0", bus.WBV); end
  endtask

  task automatic test_full_stall();
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.NEXT !== m_next()) begin errors++; $display("FAIL stall_next: got %b exp %b", bus.NEXT, m_next()); end
      if (!m_next()) break;
      rtick(1'b1, 1'b0);
      n++;
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL stall_issues: got %0d exp %0d", n, DEPTH); end
    for (int k = 0; k < LAT; k++) rtick(1'b0, 1'b0);
    checks++; if (bus.COUNT !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d exp 4", bus.COUNT); end
    checks++; if (bus.NEXT !== 1'b0) begin errors++; $display("FAIL stall_next_full: got %b exp 0", bus.NEXT); end
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (bus.WBV !== 1'b1 || bus.WBR !== exp_q[0].r || bus.WBDST !== exp_q[0].dst
                    || bus.WBSZ !== exp_q[0].sz || bus.WBFLAGS !== 5'(exp_q[0].flags)) begin
        errors++; $display("FAIL stall_drain%0d: got %h/%h exp %h/%h", k, bus.WBDST, bus.WBR, exp_q[0].dst, exp_q[0].r);
      end
      rtick(1'b0, 1'b1);
    end
    checks++; if (bus.COUNT !== 3'd0) begin errors++; $display("FAIL stall_empty: got %0d exp 0", bus.COUNT); end
    checks++; if (bus.OVERRUN !== 1'b0) begin errors++; $display("FAIL stall_overrun: got %b exp 0", bus.OVERRUN); end
  endtask

  task automatic test_streaming();
    int p0;
    p0 = npop;
    for (int i = 0; i < 20 + LAT + 2; i++) begin
      checks++; if (bus.COUNT > 3'd1 || bus.COUNT !== 3'(exp_q.size()) || bus.NEXT !== m_next()) begin
        errors++; $display("FAIL stream_state%0d: count %0d next %b exp count %0d next %b", i, bus.COUNT, bus.NEXT, exp_q.size(), m_next());
      end
      checks++; if (bus.WBV !== (exp_q.size() > 0)) begin errors++; $display("FAIL stream_wbv%0d: got %b", i, bus.WBV); end
      if (exp_q.size() > 0) begin
        checks++; if (bus.WBR !== exp_q[0].r || bus.WBDST !== exp_q[0].dst) begin
          errors++; $display("FAIL stream_head%0d: got %h exp %h", i, bus.WBR, exp_q[0].r);
        end
      end
      tick(i < 20, 5'(i), 3'($urandom), 1'b1, {96'h0, 32'hA000_0000 + 32'(i)}, 5'($urandom));
    end
    checks++; if (npop - p0 != 20) begin errors++; $display("FAIL stream_total: got %0d exp 20", npop - p0); end
  endtask

  task automatic test_overrun();
    entry_t snap[$];
    fill();
    snap = exp_q;
    checks++; if (bus.NEXT !== 1'b0) begin errors++; $display("FAIL ovr_next: got %b exp 0", bus.NEXT); end
    rtick(1'b1, 1'b0);
    checks++; if (bus.OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b exp 1", bus.OVERRUN); end
    for (int k = 0; k < LAT; k++) rtick(1'b0, 1'b0);
    checks++; if (bus.COUNT !== 3'd4) begin errors++; $display("FAIL ovr_count: got %0d exp 4", bus.COUNT); end
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (bus.WBV !== 1'b1 || bus.WBR !== snap[k].r || bus.WBDST !== snap[k].dst) begin
        errors++; $display("FAIL ovr_keep%0d: got %h exp %h", k, bus.WBR, snap[k].r);
      end
      rtick(1'b0, 1'b1);
    end
    checks++; if (bus.WBV !== 1'b0 || bus.OVERRUN !== 1'b1) begin
      errors++; $display("FAIL ovr_after: wbv %b overrun %b exp 0 1", bus.WBV, bus.OVERRUN);
    end
  endtask

  task automatic test_push_pop_full();
    entry_t second;
    fill();
    rtick(1'b1, 1'b0);
    for (int k = 0; k < LAT - 1; k++) rtick(1'b0, 1'b0);
    second = exp_q[1];
    checks++; if (bus.COUNT !== 3'd4) begin errors++; $display("FAIL pp_pre: got %0d exp 4", bus.COUNT); end
    tick(1'b0, 5'h0, 3'h0, 1'b1, 128'hFEED_BEEF, 5'b10101);
    checks++; if (bus.COUNT !== 3'd4) begin errors++; $display("FAIL pp_count: got %0d exp 4", bus.COUNT); end
    checks++; if (bus.WBR !== second.r || bus.WBDST !== second.dst) begin
      errors++; $display("FAIL pp_head: got %h exp %h", bus.WBR, second.r);
    end
    for (int k = 0; k < DEPTH - 1; k++) rtick(1'b0, 1'b1);
    checks++; if (bus.WBR !== 128'hFEED_BEEF || bus.WBFLAGS !== 5'b10101) begin
      errors++; $display("FAIL pp_tail: got %h/%b exp feedbeef/10101", bus.WBR, bus.WBFLAGS);
    end
    rtick(1'b0, 1'b1);
    checks++; if (bus.COUNT !== 3'd0) begin errors++; $display("FAIL pp_empty: got %0d exp 0", bus.COUNT); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) rtick(1'b1, 1'b0);
    checks++; if (bus.COUNT !== 3'(exp_q.size()) || exp_q.size() != 3 || pend_q.size() != 2) begin
      errors++; $display("FAIL rmid_pre: got %0d exp %0d", bus.COUNT, exp_q.size());
    end
    rst = 1'b1; bus.ACT = 1'b0; bus.WBACK = 1'b0;
    #1;
    checks++; if (bus.NEXT !== 1'b1 || bus.WBV !== 1'b0 || bus.COUNT !== 3'd0 || bus.OVERRUN !== 1'b0) begin
      errors++; $display("FAIL rmid_ctl: next %b wbv %b count %0d ovr %b exp 1 0 0 0", bus.NEXT, bus.WBV, bus.COUNT, bus.OVERRUN);
    end
    checks++; if (bus.WBR !== 128'h0 || bus.WBDST !== 5'h0 || bus.WBSZ !== 3'h0 || bus.WBFLAGS !== 5'h0) begin
      errors++; $display("FAIL rmid_head: got %h/%h/%h/%h exp zeros", bus.WBR, bus.WBDST, bus.WBSZ, bus.WBFLAGS);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); pend_q.delete(); m_ovr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rtick(1'b0, 1'b0);
      checks++; if (bus.WBV !== 1'b0 || bus.COUNT !== 3'd0 || bus.NEXT !== 1'b1 || bus.OVERRUN !== 1'b0) begin
        errors++; $display("FAIL rmid_after%0d: wbv %b count %0d next %b ovr %b", k, bus.WBV, bus.COUNT, bus.NEXT, bus.OVERRUN);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; npop = 0; m_ovr = 1'b0;
    rst = 1'b1;
    bus.ACT = 1'b0; bus.DSTi = '0; bus.SD = '0; bus.R = '0; bus.WBACK = 1'b0;
    bus.ZERO = 1'b0; bus.SIGN = 1'b0; bus.OVR = 1'b0; bus.COUT = 1'b0; bus.NaN = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_op();
    test_full_stall();
    test_streaming();
    test_overrun();
    apply_reset();
    test_push_pop_full();
    apply_reset();
    test_reset_mid();
    checks++; if (bus.OVERRUN !== m_ovr) begin errors++; $display("FAIL final_overrun: got %b exp %b", bus.OVERRUN, m_ovr); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
